safety_supervisor: RTL and testbench

- Registered, multi-channel successor to the combinational overheat/keep-driving logic.
- Per-CPU overheat persistence filter with cool-down hysteresis drives individual shutdown lines.
- A drive FSM sequences IDLE/DRIVING/RESERVE/HALTED from arrival, fuel and compute health.
- Sits between the vehicle sensor interface and the powertrain/compute power controllers.

---
 rtl/safety_supervisor.sv | 127 ++++++++++++
 tb/tb_safety_supervisor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/safety_supervisor.sv
// ---------------------------------------------------------------------------
// safety_supervisor : per-CPU overheat filter with hysteresis plus drive FSM
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module safety_supervisor #(
  parameter int NUM_CPUS        = 4,
  parameter int OVERHEAT_CYCLES = 4,
  parameter int COOL_CYCLES     = 8,
  parameter int FUEL_W          = 8,
  parameter int FUEL_RESERVE    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CPUS-1:0] cpu_overheated,
  input  logic                arrived,
  input  logic                gas_tank_empty,
  input  logic [FUEL_W-1:0]   fuel_level,
  input  logic                start,
  input  logic                resume,
  output logic [NUM_CPUS-1:0] shut_off_computer,
  output logic                keep_driving,
  output logic                low_fuel_warn,
  output logic [1:0]          drive_state
);

  localparam int CNT_MAX = (OVERHEAT_CYCLES > COOL_CYCLES) ? OVERHEAT_CYCLES : COOL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  HEAT_LAST     = CNT_W'(OVERHEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_LAST     = CNT_W'(COOL_CYCLES - 1);
  localparam logic [FUEL_W-1:0] RESERVE_LEVEL = FUEL_W'(FUEL_RESERVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVING = 2'd1,
    RESERVE = 2'd2,
    HALTED  = 2'd3
  } drive_t;

  // Each CPU has one active counter at a time: heat while running, cool while shut.
  for (genvar i = 0; i < NUM_CPUS; i++) begin : g_cpu
    logic [CNT_W-1:0] r_heat_cnt;
    logic [CNT_W-1:0] r_cool_cnt;
    logic             r_shut;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_heat_cnt <= '0;
        r_cool_cnt <= '0;
        r_shut     <= 1'b0;
      end else if (!r_shut) begin
        r_cool_cnt <= '0;
        if (!cpu_overheated[i]) begin
          r_heat_cnt <= '0;
        end else if (r_heat_cnt >= HEAT_LAST) begin
          r_heat_cnt <= '0;
          r_shut     <= 1'b1;
        end else begin
          r_heat_cnt <= r_heat_cnt + 1'b1;
        end
      end else begin
        r_heat_cnt <= '0;
        if (cpu_overheated[i]) begin
          r_cool_cnt <= '0;
        end else if (r_cool_cnt >= COOL_LAST) begin
          r_cool_cnt <= '0;
          r_shut     <= 1'b0;
        end else begin
          r_cool_cnt <= r_cool_cnt + 1'b1;
        end
      end
    end

    assign shut_off_computer[i] = r_shut;
  end

  logic   all_down;
  logic   fuel_low;
  drive_t r_state;
  drive_t next_state;

  assign all_down = &shut_off_computer;
  assign fuel_low = (fuel_level <= RESERVE_LEVEL);

  always_comb begin
    next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start && !arrived && !gas_tank_empty && !all_down)
          next_state = fuel_low ? RESERVE : DRIVING;
      end
      DRIVING: begin
        if (gas_tank_empty || all_down) next_state = HALTED;
        else if (arrived)               next_state = IDLE;
        else if (fuel_low)              next_state = RESERVE;
      end
      RESERVE: begin
        if (gas_tank_empty || all_down) next_state = HALTED;
        else if (arrived)               next_state = IDLE;
        else if (!fuel_low)             next_state = DRIVING;
      end
      HALTED: begin
        if (resume && !gas_tank_empty && !all_down) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs are registered alongside the state from the same next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      keep_driving  <= 1'b0;
      low_fuel_warn <= 1'b0;
    end else begin
      r_state       <= next_state;
      keep_driving  <= (next_state == DRIVING) || (next_state == RESERVE);
      low_fuel_warn <= (next_state == RESERVE);
    end
  end

  assign drive_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_safety_supervisor.sv
// ---------------------------------------------------------------------------
// tb_safety_supervisor : directed + randomized check against a reference model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_safety_supervisor;

  localparam int NUM_CPUS        = 4;
  localparam int OVERHEAT_CYCLES = 4;
  localparam int COOL_CYCLES     = 8;
  localparam int FUEL_W          = 8;
  localparam int FUEL_RESERVE    = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_CPUS-1:0] cpu_overheated;
  logic                arrived;
  logic                gas_tank_empty;
  logic [FUEL_W-1:0]   fuel_level;
  logic                start;
  logic                resume;
  logic [NUM_CPUS-1:0] shut_off_computer;
  logic                keep_driving;
  logic                low_fuel_warn;
  logic [1:0]          drive_state;

  safety_supervisor #(
    .NUM_CPUS       (NUM_CPUS),
    .OVERHEAT_CYCLES(OVERHEAT_CYCLES),
    .COOL_CYCLES    (COOL_CYCLES),
    .FUEL_W         (FUEL_W),
    .FUEL_RESERVE   (FUEL_RESERVE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_overheated   (cpu_overheated),
    .arrived          (arrived),
    .gas_tank_empty   (gas_tank_empty),
    .fuel_level       (fuel_level),
    .start            (start),
    .resume           (resume),
    .shut_off_computer(shut_off_computer),
    .keep_driving     (keep_driving),
    .low_fuel_warn    (low_fuel_warn),
    .drive_state      (drive_state)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: run length of samples opposing the current shut state,
  // plus the trip state as a plain integer (0 idle, 1 driving, 2 reserve, 3 halted).
  int              run_len [NUM_CPUS];
  bit [NUM_CPUS-1:0] m_shut;
  int              m_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit any_down_all;
    bit low;
    if (reset) begin
      m_state = 0;
      m_shut  = '0;
      for (int i = 0; i < NUM_CPUS; i++) run_len[i] = 0;
      return;
    end
    any_down_all = (m_shut == {NUM_CPUS{1'b1}});
    low = (int'(fuel_level) <= FUEL_RESERVE);
    case (m_state)
      0: if (start && !arrived && !gas_tank_empty && !any_down_all) m_state = low ? 2 : 1;
      1, 2: begin
        if (gas_tank_empty || any_down_all) m_state = 3;
        else if (arrived)                   m_state = 0;
        else                                m_state = low ? 2 : 1;
      end
      default: if (resume && !gas_tank_empty && !any_down_all) m_state = 0;
    endcase
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (cpu_overheated[i] != m_shut[i]) begin
        run_len[i]++;
        if (run_len[i] >= (m_shut[i] ? COOL_CYCLES : OVERHEAT_CYCLES)) begin
          m_shut[i]  = ~m_shut[i];
          run_len[i] = 0;
        end
      end else begin
        run_len[i] = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check({tag, ".shut"},  32'(shut_off_computer), 32'(m_shut));
    check({tag, ".state"}, 32'(drive_state),       32'(m_state));
    check({tag, ".keep"},  32'(keep_driving),      32'(m_state == 1 || m_state == 2));
    check({tag, ".warn"},  32'(low_fuel_warn),     32'(m_state == 2));
  endtask

  task automatic heat_bit2(input bit v, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      cpu_overheated[2] = v;
      tick(tag);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_overheated = '0; arrived = 1'b0; gas_tank_empty = 1'b0;
    fuel_level = 8'd100; start = 1'b0; resume = 1'b0;
    tick("reset");
    tick("reset");
    check("reset_idle", 32'(drive_state), 32'd0);

    reset = 1'b0; start = 1'b1;
    tick("start");
    check("start_driving", 32'(drive_state), 32'd1);
    start = 1'b0;

    heat_bit2(1'b1, 3, "burst3");
    heat_bit2(1'b0, 1, "gap");
    heat_bit2(1'b1, 3, "burst4a");
    check("no_trip_yet", 32'(shut_off_computer[2]), 32'd0);
    heat_bit2(1'b1, 1, "burst4b");
    check("trip_bit2", 32'(shut_off_computer[2]), 32'd1);
    heat_bit2(1'b0, 7, "cool7");
    heat_bit2(1'b1, 1, "reheat");
    heat_bit2(1'b0, 7, "cool8a");
    check("still_shut", 32'(shut_off_computer[2]), 32'd1);
    heat_bit2(1'b0, 1, "cool8b");
    check("released", 32'(shut_off_computer[2]), 32'd0);

    fuel_level = 8'd17; tick("fuel17");
    fuel_level = 8'd16; tick("fuel16");
    check("reserve_at_16", 32'(drive_state), 32'd2);
    fuel_level = 8'd17; tick("refuel17");
    check("driving_at_17", 32'(drive_state), 32'd1);

    arrived = 1'b1; gas_tank_empty = 1'b1; tick("arrive_empty");
    check("empty_dominates", 32'(drive_state), 32'd3);
    arrived = 1'b0; resume = 1'b1; tick("resume_empty");
    gas_tank_empty = 1'b0; tick("resume_ok");
    check("resume_idle", 32'(drive_state), 32'd0);
    resume = 1'b0;

    fuel_level = 8'd100; start = 1'b1; tick("start2");
    start = 1'b0; cpu_overheated = 4'b1111;
    for (int k = 0; k < 5; k++) tick("all_hot");
    check("all_down_halt", 32'(drive_state), 32'd3);
    cpu_overheated = 4'b0000; resume = 1'b1;
    for (int k = 0; k < 9; k++) tick("cool_resume");
    check("resume_after_cool", 32'(drive_state), 32'd0);
    resume = 1'b0;

    fuel_level = 8'd10; start = 1'b1; tick("start_reserve");
    start = 1'b0; cpu_overheated = 4'b0001;
    tick("mid_count");
    tick("mid_count");
    reset = 1'b1; tick("reset_mid");
    check("reset_mid_idle", 32'(drive_state), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick("post_reset_heat");
    check("count_restarted", 32'(shut_off_computer[0]), 32'd0);

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CPUS; i++)
        if ($urandom_range(0, 5) == 0) cpu_overheated[i] = ~cpu_overheated[i];
      if ($urandom_range(0, 199) == 0) cpu_overheated = 4'b1111;
      reset          = ($urandom_range(0, 149) == 0);
      start          = ($urandom_range(0, 3) == 0);
      arrived        = ($urandom_range(0, 19) == 0);
      gas_tank_empty = ($urandom_range(0, 24) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      fuel_level     = ($urandom_range(0, 9) == 0) ? FUEL_W'($urandom) : FUEL_W'($urandom_range(12, 20));
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
